// File: rtl/scan_refresh_ctrl_if.sv
// ---------------------------------------------------------------------------
// scan_refresh_ctrl_if
//
// Purpose:
//   Groups the display-value and scan-output signals of scan_refresh_ctrl so
//   the controller and its user connect through one bundle.
//
// Signals:
//   data_in        [31:0]  value to display; nibble k drives digit k
//   load                   single-cycle strobe that captures data_in
//   blank_mask     [7:0]   bit k = 1 forces digit k dark
//   refreshcounter [2:0]   active digit index, feeds the anode decoder
//   digit          [3:0]   nibble of the displayed value for the active digit
//   digit_blank            active digit must be dark
//   pending                a loaded value is waiting for the frame boundary
//   frame_start            one-cycle pulse at the start of each frame
//
// Modports:
//   master  drives data_in/load/blank_mask, observes the scan outputs
//   slave   the controller side (scan_refresh_ctrl)
// ---------------------------------------------------------------------------
interface scan_refresh_ctrl_if;

    logic [31:0] data_in;
    logic        load;
    logic [7:0]  blank_mask;
    logic [2:0]  refreshcounter;
    logic [3:0]  digit;
    logic        digit_blank;
    logic        pending;
    logic        frame_start;

    modport master (
        output data_in,
        output load,
        output blank_mask,
        input  refreshcounter,
        input  digit,
        input  digit_blank,
        input  pending,
        input  frame_start
    );

    modport slave (
        input  data_in,
        input  load,
        input  blank_mask,
        output refreshcounter,
        output digit,
        output digit_blank,
        output pending,
        output frame_start
    );

endinterface

// File: rtl/scan_refresh_ctrl.sv
// ---------------------------------------------------------------------------
// scan_refresh_ctrl
//
// Purpose:
//   Upstream feeder for an 8-digit multiplexed display. A prescaler divides
//   clk down to one tick per digit slot, the 3-bit refreshcounter walks the
//   digits 0..7, and the nibble plus blank flag of the active digit are
//   presented to the segment decoder. The displayed 32-bit value is double
//   buffered: a new value only becomes visible at a frame boundary (the
//   7 -> 0 wrap of refreshcounter), so a frame never mixes two values.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    scan_refresh_ctrl_if.slave
//            data_in, load, blank_mask                       (inputs)
//            refreshcounter, digit, digit_blank, pending,
//            frame_start                                     (outputs)
//
// Parameters:
//   TICK_DIV  clocks per digit slot (>= 2); prescaler width derived from it
//
// Configuration:
//   SCAN_LZB_EN  when defined, leading-zero blanking is added: digit k (k>=1)
//                goes dark when nibbles 7..k of the displayed value are all
//                zero. Digit 0 is never blanked by this rule, so the value 0
//                still shows a single "0". Undefined (default): digit_blank
//                comes from blank_mask only.
// ---------------------------------------------------------------------------
module scan_refresh_ctrl #(
    parameter int TICK_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    scan_refresh_ctrl_if.slave bus
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] PRESCALE_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] prescaler;
    logic [2:0]       refresh_q;
    logic [31:0]      display_reg;
    logic [31:0]      pending_reg;
    logic             pending_q;
    logic             frame_start_q;
    logic             tick;
    logic             wrap;

    assign tick = (prescaler == PRESCALE_LAST);
    // The wrap edge is the one tick that moves the scan from digit 7 back
    // to digit 0; it is the only place the display buffer may change.
    assign wrap = tick && (refresh_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= 3'd0;
        end else if (tick) begin
            refresh_q <= refresh_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= wrap;
        end
    end

    // A load coinciding with the wrap edge goes straight to the display and
    // supersedes anything still pending. Loads at any other time only refill
    // the shadow register, so the last one before the wrap wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_reg <= 32'd0;
            pending_reg <= 32'd0;
            pending_q   <= 1'b0;
        end else if (wrap) begin
            if (bus.load) begin
                display_reg <= bus.data_in;
            end else if (pending_q) begin
                display_reg <= pending_reg;
            end
            pending_q <= 1'b0;
        end else if (bus.load) begin
            pending_reg <= bus.data_in;
            pending_q   <= 1'b1;
        end
    end

    assign bus.refreshcounter = refresh_q;
    assign bus.digit          = display_reg[{refresh_q, 2'b00} +: 4];
    assign bus.pending        = pending_q;
    assign bus.frame_start    = frame_start_q;

`ifdef SCAN_LZB_EN
    logic [7:0] lead_zero;

    // lead_zero[k] is set when nibbles 7..k are all zero; built top-down so
    // each digit reuses the result of the digit above it.
    always_comb begin
        lead_zero    = 8'd0;
        lead_zero[7] = (display_reg[31:28] == 4'd0);
        for (int k = 6; k >= 1; k--) begin
            lead_zero[k] = lead_zero[k+1] && (display_reg[4*k +: 4] == 4'd0);
        end
    end

    assign bus.digit_blank = bus.blank_mask[refresh_q] | lead_zero[refresh_q];
`else
    assign bus.digit_blank = bus.blank_mask[refresh_q];
`endif

endmodule

// File: tb/tb_scan_refresh_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_refresh_ctrl
//
// Purpose:
//   Self-checking bench for scan_refresh_ctrl with TICK_DIV = 4. The stimulus
//   process queues the expected contents of every digit slot; a monitor
//   samples on the falling edge and, whenever refreshcounter moves to a new
//   slot, pops and compares rc/digit/digit_blank/pending, checks the slot
//   length, and checks frame_start on every cycle.
// ---------------------------------------------------------------------------
module tb_scan_refresh_ctrl;

    localparam int TICK_DIV = 4;

    typedef struct packed {
        logic [2:0] rc;
        logic [3:0] digit;
        logic       blank;
        logic       pend;
    } slot_t;

    logic  clk = 1'b0;
    logic  rst_n;
    slot_t exp_q[$];
    int    assert_count = 0;
    int    fail_count   = 0;

    scan_refresh_ctrl_if bus ();

    scan_refresh_ctrl #(
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic exp_blank(input logic [31:0] disp, input logic [7:0] mask,
                                       input int r);
        logic b;
        b = mask[r];
`ifdef SCAN_LZB_EN
        if (r >= 1 && (disp >> (4 * r)) == 32'd0) b = 1'b1;
`endif
        return b;
    endfunction

    task automatic expect_slots(input logic [31:0] disp, input logic [7:0] mask,
                                input int first, input int last, input logic pend);
        for (int r = first; r <= last; r++) begin
            slot_t s;
            s.rc    = 3'(r);
            s.digit = disp[4*r +: 4];
            s.blank = exp_blank(disp, mask, r);
            s.pend  = pend;
            exp_q.push_back(s);
        end
    endtask

    // Single-cycle load strobe; returns 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic [31:0] value);
        bus.data_in = value;
        bus.load    = 1'b1;
        @(posedge clk);
        #1;
        bus.load    = 1'b0;
    endtask

    task automatic wait_frame_start(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_slot(input int r, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.refreshcounter === 3'(r)) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    // Monitor: slot scoreboard plus per-cycle frame_start and period checks.
    initial begin
        logic [2:0] prev_rc;
        logic       changed;
        int         slot_len;
        int         cycle_no;
        int         last_fs;
        slot_t      s;
        prev_rc  = 3'd0;
        slot_len = 1;
        cycle_no = 0;
        last_fs  = -1;
        forever begin
            @(negedge clk);
            cycle_no++;
            if (!rst_n) begin
                prev_rc  = 3'd0;
                slot_len = 1;
                last_fs  = -1;
            end else begin
                changed = (bus.refreshcounter !== prev_rc);
                checkOutput("frame_start", 32'(bus.frame_start),
                            32'(changed && prev_rc == 3'd7 && bus.refreshcounter == 3'd0));
                if (bus.frame_start === 1'b1) begin
                    if (last_fs >= 0) checkOutput("frame_period", 32'(cycle_no - last_fs), 32'd32);
                    last_fs = cycle_no;
                end
                if (changed) begin
                    checkOutput("slot_length", 32'(slot_len), 32'(TICK_DIV));
                    if (exp_q.size() == 0) begin
                        assert_count++;
                        fail_count++;
                        $display("[TB] FAIL unexpected_slot: got rc=%0d, expected no further slot",
                                 bus.refreshcounter);
                    end else begin
                        s = exp_q.pop_front();
                        checkOutput("slot_rc",      32'(bus.refreshcounter), 32'(s.rc));
                        checkOutput("slot_digit",   32'(bus.digit),          32'(s.digit));
                        checkOutput("slot_blank",   32'(bus.digit_blank),    32'(s.blank));
                        checkOutput("slot_pending", 32'(bus.pending),        32'(s.pend));
                    end
                    slot_len = 1;
                    prev_rc  = bus.refreshcounter;
                end else begin
                    slot_len++;
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.load       = 1'b0;
        bus.data_in    = 32'd0;
        bus.blank_mask = 8'd0;

        // Reset state, and blank_mask acting combinationally while in reset.
        #3;
        checkOutput("reset_rc",          32'(bus.refreshcounter), 32'd0);
        checkOutput("reset_digit",       32'(bus.digit),          32'd0);
        checkOutput("reset_pending",     32'(bus.pending),        32'd0);
        checkOutput("reset_frame_start", 32'(bus.frame_start),    32'd0);
        checkOutput("reset_blank",       32'(bus.digit_blank),    32'd0);
        bus.blank_mask = 8'h01;
        #1;
        checkOutput("reset_blank_mask0", 32'(bus.digit_blank),    32'd1);
        bus.blank_mask = 8'h00;

        // Frame 0/1: free run on zero; frame 1 uses mask 0xA0 after slot 0.
        expect_slots(32'h0, 8'h00, 1, 7, 1'b0);
        expect_slots(32'h0, 8'h00, 0, 0, 1'b0);
        expect_slots(32'h0, 8'hA0, 1, 7, 1'b0);
        // Frame 2: load at slot 3, pending seen from slot 4.
        expect_slots(32'h0, 8'h00, 0, 3, 1'b0);
        expect_slots(32'h0, 8'h00, 4, 7, 1'b1);
        // Frame 3: committed 0x12345678.
        expect_slots(32'h12345678, 8'h00, 0, 7, 1'b0);
        // Frame 4: loads at slots 1 and 5, display unchanged.
        expect_slots(32'h12345678, 8'h00, 0, 1, 1'b0);
        expect_slots(32'h12345678, 8'h00, 2, 7, 1'b1);
        // Frame 5: last load 0x000000FF wins.
        expect_slots(32'h000000FF, 8'h00, 0, 7, 1'b0);
        // Frame 6: load on the wrap edge bypasses the buffer.
        expect_slots(32'hCAFE0001, 8'h00, 0, 7, 1'b0);
        // Frame 7: load at slot 2, reset during slot 5.
        expect_slots(32'hCAFE0001, 8'h00, 0, 2, 1'b0);
        expect_slots(32'hCAFE0001, 8'h00, 3, 5, 1'b1);

        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;

        // First tick lands on the 4th edge after release.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rc_before_first_tick", 32'(bus.refreshcounter), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rc_after_first_tick",  32'(bus.refreshcounter), 32'd1);

        wait_frame_start("wait_frame1");
        #1;
        bus.blank_mask = 8'hA0;
        wait_frame_start("wait_frame2");
        #1;
        bus.blank_mask = 8'h00;

        wait_slot(3, "wait_f2_slot3");
        #1;
        applyStimulus(32'h12345678);
        checkOutput("pending_after_load",  32'(bus.pending), 32'd1);
        checkOutput("digit_held_on_load",  32'(bus.digit),   32'd0);

        wait_frame_start("wait_frame3");
        wait_frame_start("wait_frame4");
        wait_slot(1, "wait_f4_slot1");
        #1;
        applyStimulus(32'hAAAAAAAA);
        wait_slot(5, "wait_f4_slot5");
        #1;
        bus.data_in = 32'h11111111;
        bus.load    = 1'b1;
        @(posedge clk);
        #1;
        bus.data_in = 32'h22222222;
        @(posedge clk);
        #1;
        bus.data_in = 32'h000000FF;
        @(posedge clk);
        #1;
        bus.load    = 1'b0;

        wait_frame_start("wait_frame5");
        wait_slot(7, "wait_f5_slot7");
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(32'hCAFE0001);
        checkOutput("wrap_load_rc",          32'(bus.refreshcounter), 32'd0);
        checkOutput("wrap_load_digit",       32'(bus.digit),          32'd1);
        checkOutput("wrap_load_pending",     32'(bus.pending),        32'd0);
        checkOutput("wrap_load_frame_start", 32'(bus.frame_start),    32'd1);

        repeat (2) @(negedge clk);
        wait_frame_start("wait_frame7");
        wait_slot(2, "wait_f7_slot2");
        #1;
        applyStimulus(32'h55555555);
        wait_slot(5, "wait_f7_slot5");
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_rc",          32'(bus.refreshcounter), 32'd0);
        checkOutput("async_reset_digit",       32'(bus.digit),          32'd0);
        checkOutput("async_reset_pending",     32'(bus.pending),        32'd0);
        checkOutput("async_reset_frame_start", 32'(bus.frame_start),    32'd0);
        checkOutput("async_reset_blank",       32'(bus.digit_blank),    32'(exp_blank(32'h0, 8'h00, 0)));

        // After reset the discarded 0x55555555 must never show; 0x00000F00
        // is loaded at slot 2 and commits at the next wrap.
        expect_slots(32'h0, 8'h00, 1, 2, 1'b0);
        expect_slots(32'h0, 8'h00, 3, 7, 1'b1);
        expect_slots(32'h00000F00, 8'h00, 0, 7, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;

        wait_slot(2, "wait_r_slot2");
        #1;
        applyStimulus(32'h00000F00);
        wait_frame_start("wait_r_frame1");
        wait_slot(7, "wait_r_slot7");
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
